// File: rtl/uart_pkg.sv
// Shared types and constants for the UART calculator datapath: byte width,
// controller state enums and a helper for sizing byte counters.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_BUSY,
    WAIT_IDLE,
    DONE
  } tx_ctrl_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_WAIT_BYTE,
    RX_STORE,
    RX_NEXT,
    RX_TRIGGER
  } rx_ctrl_state_t;

  // A byte counter is never narrower than one bit, even for a one-byte result.
  function automatic int idxWidth(input int nBytes);
    return (nBytes <= 2) ? 1 : $clog2(nBytes);
  endfunction

endpackage

// File: rtl/tx_control_byte_serializer.sv
// Parallel-load register that hands out a wide word one byte at a time,
// least significant byte first.
module byte_serializer
  import uart_pkg::*;
#(
  parameter int N_BYTES = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_load,
  input  logic                      i_shift,
  input  logic [BYTE_W*N_BYTES-1:0] i_data,
  output logic [BYTE_W-1:0]         o_cur_byte
);

  logic [BYTE_W*N_BYTES-1:0] r_shift;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_shift <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
    end else if (i_shift) begin
      r_shift <= r_shift >> BYTE_W;
    end
  end

  assign o_cur_byte = r_shift[BYTE_W-1:0];

endmodule

// File: rtl/tx_control.sv
// Transmit sequencer: captures the ALU result on a trigger and feeds it to
// UART_tx byte by byte with a start/busy handshake, then pulses done.
module tx_control
  import uart_pkg::*;
#(
  parameter int N_BYTES = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_trigger,
  input  logic [BYTE_W*N_BYTES-1:0] i_result,
  input  logic                      i_tx_busy,
  output logic                      o_tx_start,
  output logic [BYTE_W-1:0]         o_tx_data,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int IDX_W = idxWidth(N_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  tx_ctrl_state_t    r_state;
  tx_ctrl_state_t    w_nextState;
  logic [IDX_W-1:0]  r_idx;
  logic [BYTE_W-1:0] r_txData;
  logic              r_busy;
  logic              r_done;
  logic              w_load;
  logic              w_handoff;
  logic              w_advance;
  logic              w_lastByte;
  logic [BYTE_W-1:0] w_curByte;

  assign w_lastByte = (r_idx == LAST_IDX);
  assign w_load     = (r_state == IDLE) && i_trigger;
  assign w_handoff  = (r_state == SEND) && !i_tx_busy;
  assign w_advance  = (r_state == WAIT_IDLE) && !i_tx_busy && !w_lastByte;

  // The serializer steps as soon as a byte is handed off, so the following
  // byte is already sitting at its output when WAIT_IDLE moves on to LOAD.
  byte_serializer #(
    .N_BYTES(N_BYTES)
  ) u_serializer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (w_load),
    .i_shift   (w_handoff),
    .i_data    (i_result),
    .o_cur_byte(w_curByte)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:      if (i_trigger) w_nextState = LOAD;
      LOAD:      w_nextState = SEND;
      SEND:      if (!i_tx_busy) w_nextState = WAIT_BUSY;
      WAIT_BUSY: if (i_tx_busy) w_nextState = WAIT_IDLE;
      WAIT_IDLE: if (!i_tx_busy) w_nextState = w_lastByte ? DONE : LOAD;
      DONE:      w_nextState = IDLE;
      default:   w_nextState = IDLE;
    endcase
  end

  // tx_data is written on entry to LOAD so it is stable for the whole LOAD
  // cycle ahead of the start pulse, and it keeps the last byte once idle.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_txData <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_busy  <= (w_nextState != IDLE);
      r_done  <= (w_nextState == DONE);
      if (r_state == IDLE) begin
        r_idx <= '0;
      end else if (w_advance) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_load) begin
        r_txData <= i_result[BYTE_W-1:0];
      end else if (w_advance) begin
        r_txData <= w_curByte;
      end
    end
  end

  // The start pulse has to answer tx_busy within the same cycle.
  assign o_tx_start = w_handoff;
  assign o_tx_data  = r_txData;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_tx_control.sv
// Self-checking bench for tx_control with 2-byte and 4-byte instances and a
// behavioural UART_tx model driving tx_busy.
module tb_tx_control;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN = 1'b0;

  logic        trig2 = 1'b0;
  logic [15:0] res2 = '0;
  logic        manBusy2 = 1'b0;
  logic        modelBusy2 = 1'b0;
  logic        busyIn2;
  logic        start2, busyo2, done2;
  logic [7:0]  data2;

  logic        trig4 = 1'b0;
  logic [31:0] res4 = '0;
  logic        modelBusy4 = 1'b0;
  logic        busyIn4;
  logic        start4, busyo4, done4;
  logic [7:0]  data4;

  assign busyIn2 = manBusy2 | modelBusy2;
  assign busyIn4 = modelBusy4;

  tx_control #(.N_BYTES(2)) dut2 (
    .i_clk(clk), .i_reset(rstN), .i_trigger(trig2), .i_result(res2),
    .i_tx_busy(busyIn2), .o_tx_start(start2), .o_tx_data(data2),
    .o_busy(busyo2), .o_done(done2)
  );

  tx_control #(.N_BYTES(4)) dut4 (
    .i_clk(clk), .i_reset(rstN), .i_trigger(trig4), .i_result(res4),
    .i_tx_busy(busyIn4), .o_tx_start(start4), .o_tx_data(data4),
    .o_busy(busyo4), .o_done(done4)
  );

  // UART_tx model: after seeing a start, waits lat cycles, then stays busy
  // for len cycles. It is deliberately not reset with the controller.
  int lat = 0;
  int len = 10;
  int m2St = 0, m2Cnt = 0, m4St = 0, m4Cnt = 0;

  always @(posedge clk) begin
    case (m2St)
      0: if (start2) begin m2Cnt <= lat; m2St <= 1; end
      1: if (m2Cnt == 0) begin modelBusy2 <= 1'b1; m2Cnt <= len; m2St <= 2; end
         else m2Cnt <= m2Cnt - 1;
      default: if (m2Cnt <= 1) begin modelBusy2 <= 1'b0; m2St <= 0; end
               else m2Cnt <= m2Cnt - 1;
    endcase
  end

  always @(posedge clk) begin
    case (m4St)
      0: if (start4) begin m4Cnt <= lat; m4St <= 1; end
      1: if (m4Cnt == 0) begin modelBusy4 <= 1'b1; m4Cnt <= len; m4St <= 2; end
         else m4Cnt <= m4Cnt - 1;
      default: if (m4Cnt <= 1) begin modelBusy4 <= 1'b0; m4St <= 0; end
               else m4Cnt <= m4Cnt - 1;
    endcase
  end

  // Observation state, updated once per cycle from the main process only.
  logic [7:0] log2[$];
  logic [7:0] log4[$];
  int cyc = 0, checks = 0, failures = 0;
  int doneCnt2 = 0, doneCnt4 = 0, doneCyc2 = 0, fall2 = 0, firstStart2 = 0, gap2 = 0;
  logic prevStart2 = 1'b0, prevBusy2 = 1'b0, prevStart4 = 1'b0;
  logic [7:0] prevData2 = '0, prevData4 = '0;

  typedef struct {
    logic [15:0] value;
    int          lat;
    int          len;
    int          mode;
    logic [7:0]  e0;
    logic [7:0]  e1;
  } vec_t;

  vec_t vecs[5];

  // Reference: byte k of a transaction is simply bits 8k+7..8k of the captured word.
  function automatic logic [7:0] refByte(input logic [31:0] v, input int k);
    logic [31:0] s;
    s = v >> (8 * k);
    return s[7:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (start2) begin
      checkOutput("start2_while_busy", busyIn2, 0);
      checkOutput("start2_back_to_back", prevStart2, 0);
      checkOutput("data2_setup", data2, prevData2);
      if (log2.size() == 0) firstStart2 = cyc;
      else gap2 = cyc - fall2;
      log2.push_back(data2);
    end
    if (done2) begin doneCnt2++; doneCyc2 = cyc; end
    if (prevBusy2 && !busyIn2) fall2 = cyc;
    prevStart2 = start2; prevBusy2 = busyIn2; prevData2 = data2;
    if (start4) begin
      checkOutput("start4_while_busy", busyIn4, 0);
      checkOutput("start4_back_to_back", prevStart4, 0);
      checkOutput("data4_setup", data4, prevData4);
      log4.push_back(data4);
    end
    if (done4) doneCnt4++;
    prevStart4 = start4; prevData4 = data4;
  endtask

  // mode 0: quiet; 1: random retriggers and result churn; 2: constant
  // retrigger with 16'h1234, including a trigger in the DONE cycle.
  task automatic applyStimulus2(input logic [15:0] value, input int mode,
                                input logic [7:0] e0, input logic [7:0] e1, input string tag);
    bit ok;
    int t0;
    int d0;
    log2.delete();
    d0 = doneCnt2;
    res2 = value; trig2 = 1'b1; t0 = cyc;
    tick();
    trig2 = 1'b0; res2 = ~value;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      if (mode == 1) begin trig2 = busyo2 & ($urandom_range(0, 3) == 0); res2 = 16'($urandom); end
      else if (mode == 2) begin trig2 = busyo2; res2 = 16'h1234; end
      tick();
      if (doneCnt2 != d0) ok = 1'b1;
    end
    checkOutput({tag, "_done_seen"}, 32'(ok), 1);
    if (ok) begin
      checkOutput({tag, "_busy_in_done"}, busyo2, 1);
      checkOutput({tag, "_done_after_fall"}, doneCyc2 - fall2, 1);
      checkOutput({tag, "_start_latency"}, firstStart2 - t0, 2);
      checkOutput({tag, "_gap"}, gap2, 2);
    end
    trig2 = (mode == 2); res2 = 16'h1234;
    tick();
    trig2 = 1'b0;
    checkOutput({tag, "_busy_after_done"}, busyo2, 0);
    checkOutput({tag, "_done_width"}, done2, 0);
    repeat (6) tick();
    checkOutput({tag, "_nstarts"}, log2.size(), 2);
    if (log2.size() == 2) begin
      checkOutput({tag, "_byte0"}, log2[0], e0);
      checkOutput({tag, "_byte1"}, log2[1], e1);
    end
    checkOutput({tag, "_ndone"}, doneCnt2 - d0, 1);
  endtask

  task automatic applyStimulus4(input logic [31:0] value, input string tag);
    bit ok;
    int d0;
    log4.delete();
    d0 = doneCnt4;
    res4 = value; trig4 = 1'b1;
    tick();
    trig4 = 1'b0; res4 = ~value;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      trig4 = busyo4 & ($urandom_range(0, 3) == 0);
      tick();
      if (doneCnt4 != d0) ok = 1'b1;
    end
    trig4 = 1'b0;
    checkOutput({tag, "_done_seen"}, 32'(ok), 1);
    repeat (6) tick();
    checkOutput({tag, "_nstarts"}, log4.size(), 4);
    if (log4.size() == 4) begin
      for (int k = 0; k < 4; k++)
        checkOutput($sformatf("%s_byte%0d", tag, k), log4[k], refByte(value, k));
    end
    checkOutput({tag, "_ndone"}, doneCnt4 - d0, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    int d0;
    logic [15:0] v;

    vecs[0] = '{16'hBEEF, 0, 10, 0, 8'hEF, 8'hBE};
    vecs[1] = '{16'hBEEF, 1, 6, 2, 8'hEF, 8'hBE};
    vecs[2] = '{16'h0000, 2, 1, 0, 8'h00, 8'h00};
    vecs[3] = '{16'hFF01, 3, 3, 1, 8'h01, 8'hFF};
    vecs[4] = '{16'h8001, 0, 12, 1, 8'h01, 8'h80};

    // Reset held with trigger high: everything stays at zero.
    rstN = 1'b0; trig2 = 1'b1; trig4 = 1'b1; res2 = 16'hA5A5; res4 = 32'hDEADBEEF;
    repeat (3) begin
      tick();
      checkOutput("rst_start2", start2, 0);
      checkOutput("rst_data2", data2, 0);
      checkOutput("rst_busy2", busyo2, 0);
      checkOutput("rst_done2", done2, 0);
      checkOutput("rst_start4", start4, 0);
      checkOutput("rst_busy4", busyo4, 0);
    end
    trig2 = 1'b0; trig4 = 1'b0; rstN = 1'b1;
    repeat (2) tick();
    checkOutput("post_rst_idle", busyo2, 0);

    for (int i = 0; i < 5; i++) begin
      lat = vecs[i].lat; len = vecs[i].len;
      applyStimulus2(vecs[i].value, vecs[i].mode, vecs[i].e0, vecs[i].e1, $sformatf("vec%0d", i));
    end
    checkOutput("idle_holds_last_byte", data2, 8'h80);

    // tx_busy already high at trigger: the first start waits for it to drop.
    lat = 0; len = 5;
    log2.delete();
    manBusy2 = 1'b1; res2 = 16'hBEEF; trig2 = 1'b1;
    tick();
    trig2 = 1'b0; res2 = 16'h0000;
    repeat (4) tick();
    checkOutput("entry_start_withheld", log2.size(), 0);
    checkOutput("entry_busy", busyo2, 1);
    @(posedge clk);
    #1 manBusy2 = 1'b0;
    d0 = doneCnt2; found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (doneCnt2 != d0) found = 1'b1;
    end
    checkOutput("entry_done_seen", 32'(found), 1);
    repeat (4) tick();
    checkOutput("entry_nstarts", log2.size(), 2);
    if (log2.size() == 2) begin
      checkOutput("entry_byte0", log2[0], 8'hEF);
      checkOutput("entry_byte1", log2[1], 8'hBE);
    end

    // Reset while byte 0 is still on the line.
    lat = 0; len = 8;
    log2.delete();
    d0 = doneCnt2;
    res2 = 16'hBEEF; trig2 = 1'b1;
    tick();
    trig2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (log2.size() == 1 && busyIn2) found = 1'b1;
    end
    checkOutput("midrst_reached_byte0", 32'(found), 1);
    tick();
    rstN = 1'b0;
    tick();
    checkOutput("midrst_busy", busyo2, 0);
    checkOutput("midrst_start", start2, 0);
    checkOutput("midrst_data", data2, 0);
    checkOutput("midrst_done", done2, 0);
    rstN = 1'b1;
    repeat (30) tick();
    checkOutput("midrst_no_more_starts", log2.size(), 1);
    checkOutput("midrst_no_done", doneCnt2 - d0, 0);

    // Randomized transactions against the reference byte split.
    for (int i = 0; i < 12; i++) begin
      v = 16'($urandom);
      lat = $urandom_range(0, 3); len = $urandom_range(1, 12);
      applyStimulus2(v, $urandom_range(0, 2), refByte(32'(v), 0), refByte(32'(v), 1),
                     $sformatf("rnd%0d", i));
    end

    // Four-byte instance.
    lat = 1; len = 4;
    applyStimulus4(32'h01020304, "n4_fixed");
    for (int i = 0; i < 3; i++) begin
      lat = $urandom_range(0, 2); len = $urandom_range(1, 8);
      applyStimulus4($urandom, $sformatf("n4_rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
